// File: rtl/stream_collect.sv
// Purpose: merge IN_NB beat streams in strict fixed order, CHUNK_NB beats per input per round.
// Latency: 0 cycles by default; 1 cycle via 2-entry skid buffer when STREAM_COLLECT_OUT_PIPE_EN is defined.
// Backpressure: only the selected input sees ready; a stalled output or idle selected input freezes the round.
module stream_collect #(
    parameter int OP_W     = 32,
    parameter int COEF     = 8,
    parameter int IN_NB    = 4,
    parameter int CHUNK_NB = 2
) (
    input  logic                                        clk,
    input  logic                                        s_rst_n,
    input  logic [IN_NB-1:0][COEF-1:0][OP_W-1:0]        in_data,
    input  logic [IN_NB-1:0]                            in_vld,
    output logic [IN_NB-1:0]                            in_rdy,
    output logic [COEF-1:0][OP_W-1:0]                   out_data,
    output logic                                        out_vld,
    input  logic                                        out_rdy,
    output logic [((IN_NB > 1) ? $clog2(IN_NB) : 1)-1:0] out_src,
    output logic                                        out_last
);

    localparam int SRC_W = (IN_NB > 1) ? $clog2(IN_NB) : 1;
    localparam int CNT_W = (CHUNK_NB > 1) ? $clog2(CHUNK_NB) : 1;
    localparam logic [SRC_W-1:0] SEL_MAX = SRC_W'(IN_NB - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHUNK_NB - 1);

    typedef struct packed {
        logic [COEF-1:0][OP_W-1:0] dat;
        logic [SRC_W-1:0]          src;
        logic                      last;
    } beat_t;

    logic [SRC_W-1:0] sel;
    logic [CNT_W-1:0] cnt;
    logic             sel_rdy;
    logic             acc;
    beat_t            in_beat;

    assign in_beat.dat  = in_data[sel];
    assign in_beat.src  = sel;
    assign in_beat.last = (sel == SEL_MAX) && (cnt == CNT_MAX);
    assign acc          = in_vld[sel] & sel_rdy;

    always_comb begin
        in_rdy      = '0;
        in_rdy[sel] = sel_rdy;
    end

    // Round position only moves on an accepted beat from the selected input.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            sel <= '0;
            cnt <= '0;
        end else if (acc) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                sel <= (sel == SEL_MAX) ? '0 : sel + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef STREAM_COLLECT_OUT_PIPE_EN
    beat_t main_q;
    beat_t skid_q;
    logic  main_vld;
    logic  skid_vld;

    // Ready depends only on skid occupancy, so out_rdy never reaches in_rdy combinationally.
    assign sel_rdy = s_rst_n & ~skid_vld;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_rdy) begin
            main_vld <= skid_vld | acc;
            skid_vld <= 1'b0;
            if (skid_vld) begin
                main_q <= skid_q;
            end else if (acc) begin
                main_q <= in_beat;
            end
        end else if (acc) begin
            skid_q   <= in_beat;
            skid_vld <= 1'b1;
        end
    end

    assign out_vld  = main_vld;
    assign out_data = main_q.dat;
    assign out_src  = main_q.src;
    assign out_last = main_q.last;
`else
    assign sel_rdy  = s_rst_n & out_rdy;
    assign out_vld  = s_rst_n & in_vld[sel];
    assign out_data = in_beat.dat;
    assign out_src  = in_beat.src;
    assign out_last = in_beat.last;
`endif

endmodule

// File: tb/tb_stream_collect.sv
// Directed bench for stream_collect (IN_NB=4, CHUNK_NB=2) plus a randomised IN_NB=3, CHUNK_NB=1 instance.
module tb_stream_collect;

    localparam int OP_W = 32;
    localparam int COEF = 8;
    localparam int N    = 4;
    localparam int CH   = 2;
`ifdef STREAM_COLLECT_OUT_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef logic [COEF-1:0][OP_W-1:0] beat_t;
    typedef logic [1:0][OP_W-1:0]      beat3_t;
    typedef struct {
        beat_t dat;
        int    src;
        logic  last;
    } rx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 s_rst_n;
    logic [N-1:0][COEF-1:0][OP_W-1:0] in_data;
    logic [N-1:0]         in_vld;
    logic [N-1:0]         in_rdy;
    beat_t                out_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic [1:0]           out_src;
    logic                 out_last;

    logic                 r_rst_n;
    logic [2:0][1:0][OP_W-1:0] r_in_data;
    logic [2:0]           r_in_vld;
    logic [2:0]           r_in_rdy;
    beat3_t               r_out_data;
    logic                 r_out_vld;
    logic                 r_out_rdy;
    logic [1:0]           r_out_src;
    logic                 r_out_last;

    stream_collect #(.OP_W(OP_W), .COEF(COEF), .IN_NB(N), .CHUNK_NB(CH)) dut (
        .clk(clk), .s_rst_n(s_rst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_src(out_src), .out_last(out_last)
    );

    stream_collect #(.OP_W(OP_W), .COEF(2), .IN_NB(3), .CHUNK_NB(1)) dut3 (
        .clk(clk), .s_rst_n(r_rst_n), .in_data(r_in_data), .in_vld(r_in_vld), .in_rdy(r_in_rdy),
        .out_data(r_out_data), .out_vld(r_out_vld), .out_rdy(r_out_rdy), .out_src(r_out_src), .out_last(r_out_last)
    );

    int checks   = 0;
    int failures = 0;
    int seq[N];
    int r_seq[3];
    int acc_cnt;
    rx_t rxq[$];

    // State sampled mid-cycle, just before the clock edge that ends the cycle.
    logic       s_out_vld;
    logic [N-1:0] s_in_rdy;
    beat_t      s_out_data;
    int         s_out_src;
    logic       s_out_last;

    function automatic beat_t mkbeat(int i, int s);
        beat_t b;
        for (int w = 0; w < COEF; w++) b[w] = {8'(i), 16'(s), 8'(w)};
        return b;
    endfunction

    function automatic beat3_t mkbeat3(int i, int s);
        beat3_t b;
        for (int w = 0; w < 2; w++) b[w] = {8'(i), 16'(s), 8'(w)};
        return b;
    endfunction

    // Reference round-robin model for the main instance, indexed by output beat number since reset.
    function automatic int exp_src(int k);
        return (k / CH) % N;
    endfunction
    function automatic int exp_seq(int k);
        return (k / (CH * N)) * CH + k % CH;
    endfunction
    function automatic logic exp_last(int k);
        return (k % (CH * N)) == (CH * N - 1);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) in_data[i] = mkbeat(i, seq[i]);
    endtask

    task automatic r_drive();
        for (int i = 0; i < 3; i++) r_in_data[i] = mkbeat3(i, r_seq[i]);
    endtask

    task automatic cycle();
        logic [N-1:0] hs;
        logic         oh;
        rx_t          r;
        #4;
        hs = in_vld & in_rdy;
        oh = out_vld & out_rdy;
        s_out_vld  = out_vld;
        s_in_rdy   = in_rdy;
        s_out_data = out_data;
        s_out_src  = int'(out_src);
        s_out_last = out_last;
        r.dat  = out_data;
        r.src  = int'(out_src);
        r.last = out_last;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
        acc_cnt += $countones(hs);
        if (oh) rxq.push_back(r);
        drive_data();
    endtask

    task automatic do_reset(int ncyc);
        s_rst_n = 1'b0;
        repeat (ncyc) cycle();
        for (int i = 0; i < N; i++) seq[i] = 0;
        acc_cnt = 0;
        rxq.delete();
        drive_data();
        s_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        in_vld  = '1;
        out_rdy = 1'b1;
        cycle();
        cycle();
        checks++;
        if (s_out_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_vld got=%b exp=0", s_out_vld);
        end
        checks++;
        if (s_in_rdy !== '0) begin
            failures++;
            $display("FAIL reset_in_rdy got=%b exp=0000", s_in_rdy);
        end
    endtask

    task automatic test_round_robin();
        in_vld  = '1;
        out_rdy = 1'b1;
        do_reset(2);
        cycle();
        checks++;
        if (s_out_vld !== (LAT == 0)) begin
            failures++;
            $display("FAIL rr_latency out_vld=%b exp=%b", s_out_vld, (LAT == 0));
        end
        repeat (15 + LAT) cycle();
        checks++;
        if (rxq.size() != 16) begin
            failures++;
            $display("FAIL rr_throughput beats=%0d exp=16", rxq.size());
        end
        for (int k = 0; k < 16 && k < rxq.size(); k++) begin
            checks++;
            if (rxq[k].src != exp_src(k) || rxq[k].last !== exp_last(k) ||
                rxq[k].dat !== mkbeat(exp_src(k), exp_seq(k))) begin
                failures++;
                $display("FAIL rr_beat k=%0d src=%0d exp=%0d last=%b exp=%b dat0=%h exp0=%h", k, rxq[k].src,
                         exp_src(k), rxq[k].last, exp_last(k), rxq[k].dat[0], mkbeat(exp_src(k), exp_seq(k)) ,);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        in_vld  = 4'b0001;
        out_rdy = 1'b1;
        do_reset(2);
        n = 0;
        while (acc_cnt < 2 && n < 20) begin
            cycle();
            n++;
        end
        in_vld = 4'b1101;
        cycle();
        cycle();
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (s_out_vld !== 1'b0 || (s_in_rdy & in_vld) !== '0 || (s_in_rdy & 4'b1101) !== '0) begin
                failures++;
                $display("FAIL stall c=%0d out_vld=%b in_rdy=%b exp out_vld=0 in_rdy&1101=0", c, s_out_vld, s_in_rdy);
            end
        end
        checks++;
        if (acc_cnt != 2) begin
            failures++;
            $display("FAIL stall_accepts got=%0d exp=2", acc_cnt);
        end
        rxq.delete();
        in_vld = 4'b1111;
        n = 0;
        while (rxq.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (rxq.size() == 0) begin
            failures++;
            $display("FAIL stall_resume got=no_beat exp=beat_from_input1");
        end else if (rxq[0].src != 1 || rxq[0].dat !== mkbeat(1, 0)) begin
            failures++;
            $display("FAIL stall_resume src=%0d exp=1 dat0=%h exp0=%h", rxq[0].src, rxq[0].dat[0], mkbeat(1, 0) ,);
        end
    endtask

    task automatic test_backpressure();
        beat_t r_dat;
        int    r_src;
        logic  r_last;
        int    bad;
        in_vld  = '1;
        out_rdy = 1'b1;
        do_reset(2);
        repeat (5) cycle();
        out_rdy = 1'b0;
        cycle();
        r_dat  = s_out_data;
        r_src  = s_out_src;
        r_last = s_out_last;
        checks++;
        if (s_out_vld !== 1'b1) begin
            failures++;
            $display("FAIL bp_vld got=%b exp=1", s_out_vld);
        end
        for (int c = 1; c < 3; c++) begin
            cycle();
            checks++;
            if (s_out_vld !== 1'b1 || s_out_data !== r_dat || s_out_src != r_src || s_out_last !== r_last) begin
                failures++;
                $display("FAIL bp_hold c=%0d vld=%b src=%0d exp=%0d last=%b exp=%b", c, s_out_vld, s_out_src, r_src,
                         s_out_last, r_last);
            end
        end
        checks++;
        if (s_in_rdy !== '0) begin
            failures++;
            $display("FAIL bp_in_rdy got=%b exp=0000", s_in_rdy);
        end
        out_rdy = 1'b1;
        repeat (20) cycle();
        checks++;
        if (rxq.size() != 25 - LAT) begin
            failures++;
            $display("FAIL bp_count beats=%0d exp=%0d", rxq.size(), 25 - LAT);
        end
        bad = 0;
        for (int k = 0; k < rxq.size(); k++)
            if (rxq[k].src != exp_src(k) || rxq[k].last !== exp_last(k) ||
                rxq[k].dat !== mkbeat(exp_src(k), exp_seq(k))) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_sequence bad_beats=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        in_vld  = '1;
        out_rdy = 1'b1;
        do_reset(2);
        n = 0;
        while (acc_cnt < 5 && n < 20) begin
            cycle();
            n++;
        end
        s_rst_n = 1'b0;
        cycle();
        checks++;
        if (s_out_vld !== 1'b0 || s_in_rdy !== '0) begin
            failures++;
            $display("FAIL midreset_idle out_vld=%b in_rdy=%b exp=0/0000", s_out_vld, s_in_rdy);
        end
        for (int i = 0; i < N; i++) seq[i] = 0;
        rxq.delete();
        drive_data();
        s_rst_n = 1'b1;
        cycle();
        checks++;
        if (s_out_vld !== (LAT == 0)) begin
            failures++;
            $display("FAIL midreset_latency out_vld=%b exp=%b", s_out_vld, (LAT == 0));
        end
        n = 0;
        while (rxq.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (rxq.size() == 0) begin
            failures++;
            $display("FAIL midreset_first got=no_beat exp=input0_beat0");
        end else if (rxq[0].src != 0 || rxq[0].last !== 1'b0 || rxq[0].dat !== mkbeat(0, 0)) begin
            failures++;
            $display("FAIL midreset_first src=%0d exp=0 dat0=%h exp0=%h", rxq[0].src, rxq[0].dat[0], mkbeat(0, 0) ,);
        end
    endtask

    task automatic test_random();
        int k;
        int cyc;
        logic [2:0] hs;
        logic got;
        beat3_t b;
        int src;
        logic last;
        r_rst_n   = 1'b0;
        r_in_vld  = '0;
        r_out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) r_seq[i] = 0;
        r_drive();
        r_rst_n = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 10000 && cyc < 40000) begin
            r_in_vld  = 3'($urandom_range(0, 7));
            r_out_rdy = ($urandom_range(0, 3) != 0);
            #4;
            hs   = r_in_vld & r_in_rdy;
            got  = r_out_vld & r_out_rdy;
            b    = r_out_data;
            src  = int'(r_out_src);
            last = r_out_last;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (hs[i]) r_seq[i]++;
            r_drive();
            if (got) begin
                checks++;
                if (src != k % 3 || last !== (k % 3 == 2) || b !== mkbeat3(k % 3, k / 3)) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL rand_beat k=%0d src=%0d exp=%0d last=%b dat0=%h exp0=%h", k, src, k % 3, last,
                                 b[0], mkbeat3(k % 3, k / 3) ,);
                end
                k++;
            end
            cyc++;
        end
        checks++;
        if (k != 10000) begin
            failures++;
            $display("FAIL rand_timeout beats=%0d exp=10000", k);
        end
    endtask

    initial begin
        s_rst_n   = 1'b0;
        r_rst_n   = 1'b0;
        in_vld    = '0;
        out_rdy   = 1'b0;
        r_in_vld  = '0;
        r_out_rdy = 1'b0;
        acc_cnt   = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        for (int i = 0; i < 3; i++) r_seq[i] = 0;
        drive_data();
        r_drive();
        test_reset();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_collect.md
STREAM_COLLECT -- requirements
Module: stream_collect

Interface
REQ-001 SHALL have parameter OP_W, default 32, bit width of one word.
REQ-002 SHALL have parameter COEF, default 8, words per beat on every port.
REQ-003 SHALL have parameter IN_NB, default 4, number of input streams (>=2).
REQ-004 SHALL have parameter CHUNK_NB, default 2, consecutive beats taken from one input before moving to the next (>=1, any integer).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port s_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_data  input  IN_NB x COEF x OP_W  per-input beat data.
REQ-008 SHALL have port in_vld  input  IN_NB  per-input valid.
REQ-009 SHALL have port in_rdy  output  IN_NB  per-input ready.
REQ-010 SHALL have port out_data  output  COEF x OP_W  merged beat data.
REQ-011 SHALL have port out_vld  output  1  merged valid.
REQ-012 SHALL have port out_rdy  input  1  merged ready.
REQ-013 SHALL have port out_src  output  max(1,clog2(IN_NB))  index of the input the current out beat came from.
REQ-014 SHALL have port out_last  output  1  high on the last beat of a full round (input IN_NB-1, beat CHUNK_NB-1).

Function
REQ-015 SHALL merge inputs in strict fixed order: CHUNK_NB beats from input 0, then input 1, ..., input IN_NB-1, then wrap to 0; no input is ever skipped.
REQ-016 SHALL hold a source pointer sel (0..IN_NB-1) and a beat counter cnt (0..CHUNK_NB-1).
REQ-017 SHALL count a beat accepted only when in_vld[sel] & in_rdy[sel] are both high in the same cycle.
REQ-018 SHALL, on an accepted beat, increment cnt; when cnt==CHUNK_NB-1, set cnt to 0 and advance sel, wrapping IN_NB-1 to 0.
REQ-019 SHALL drive in_rdy[i] low for every i!=sel regardless of in_vld or out_rdy.
REQ-020 SHALL stall (no pointer/counter change, out_vld low) while in_vld[sel] is low, even if other inputs are valid.
REQ-021 SHALL transfer data unmodified: out_data equals the accepted in_data[sel] beat, word order preserved.
REQ-022 SHALL present out_src and out_last aligned with the out_data beat they describe and stable while out_vld & ~out_rdy.
REQ-023 SHALL, with CHUNK_NB==1, advance sel on every accepted beat.
REQ-024 SHALL sustain one beat per cycle when the selected input is always valid and out_rdy is always high, including across sel changes and round wrap.
REQ-025 SHALL keep out_vld, once asserted, high with out_data, out_src, out_last unchanged until out_rdy is sampled high.

Reset
REQ-026 SHALL, while s_rst_n is low, set sel=0, cnt=0, out_vld=0, all in_rdy=0, and discard any buffered beat.
REQ-027 SHALL, on reset mid-round, restart at input 0 beat 0 in the first cycle after s_rst_n rises; partial-chunk progress is lost.
REQ-028 SHALL not require reset of data storage; out_data is don't-care while out_vld is low.

Configuration
REQ-029 SHALL compile in an output register stage when macro STREAM_COLLECT_OUT_PIPE_EN is defined.
REQ-030 SHALL, with STREAM_COLLECT_OUT_PIPE_EN defined, use a 2-entry skid buffer on out_data/out_src/out_last/out_vld: 1-cycle latency in to out, full throughput, in_rdy[sel] derived from buffer occupancy only (no combinational path out_rdy -> in_rdy).
REQ-031 SHALL, without STREAM_COLLECT_OUT_PIPE_EN, be combinational in to out: out_vld=in_vld[sel], out_data=in_data[sel], in_rdy[sel]=out_rdy, latency 0.
REQ-032 SHALL keep ordering, counting and reset behaviour identical in both configurations.

Verification
REQ-033 SHALL cover: IN_NB=4, CHUNK_NB=2, all in_vld=1, out_rdy=1, beats tagged by source -> out_src sequence 0,0,1,1,2,2,3,3,0..., out_last high on beats 8,16; one beat/cycle.
REQ-034 SHALL cover: sel=1, in_vld=4'b1101 for 5 cycles -> out_vld low, no in_rdy high, sel stays 1; then in_vld[1]=1 -> input 1 beat accepted next.
REQ-035 SHALL cover: out_rdy low for 3 cycles with out_vld high -> out_data/out_src/out_last constant, in_rdy[sel] low (after buffer full if pipe enabled), no beat lost or duplicated.
REQ-036 SHALL cover: CHUNK_NB=1, IN_NB=3, random in_vld/out_rdy 10000 beats -> output matches reference round-robin model, zero mismatches.
REQ-037 SHALL cover: s_rst_n low for 1 cycle at sel=2, cnt=1 -> first beat after reset from input 0, out_src=0, out_vld low during reset.
REQ-038 SHALL cover: both with and without STREAM_COLLECT_OUT_PIPE_EN -> identical output beat sequence; latency 1 vs 0 cycles.
